// File: rtl/nv_clk_gate_pkg.sv
// Shared types and constants for the gated-domain clock-enable controller.
package nv_clk_gate_pkg;

    typedef enum logic [1:0] {
        CG_RUN   = 2'd0,
        CG_GATED = 2'd1,
        CG_WAKE  = 2'd2
    } cg_state_e;

    localparam int WAKE_CYC_MIN = 1;
    localparam int WAKE_CYC_MAX = 15;
    localparam int WCNT_W       = 4;
    localparam int GATE_CNT_W   = 16;

endpackage

// File: rtl/nv_clk_gate_hyst_cnt.sv
// Saturating idle-cycle counter; hit means the idle run reached the threshold.
module nv_clk_gate_hyst_cnt #(
    parameter int HYST_W = 8
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              clr,
    input  logic              inc,
    input  logic [HYST_W-1:0] thresh,
    output logic              hit
);

    logic [HYST_W-1:0] icnt;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            icnt <= '0;
        end else if (clr) begin
            icnt <= '0;
        end else if (inc && (icnt != '1)) begin
            icnt <= icnt + 1'b1;
        end
    end

    // >= so a threshold lowered below the running count still gates
    assign hit = (icnt >= thresh);

endmodule

// File: rtl/nv_clk_gate_ctrl.sv
// Clock-enable controller: gates after an idle run, warms up before accepting.
module nv_clk_gate_ctrl
    import nv_clk_gate_pkg::*;
#(
    parameter int HYST_W   = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  busy,
    input  logic [HYST_W-1:0]     idle_thresh,
    input  logic                  cg_disable,
    output logic                  clk_en,
    output logic [1:0]            cg_state,
    output logic [GATE_CNT_W-1:0] gate_cnt
);

    localparam int WAKE_EFF =
        (WAKE_CYC < WAKE_CYC_MIN) ? WAKE_CYC_MIN :
        (WAKE_CYC > WAKE_CYC_MAX) ? WAKE_CYC_MAX : WAKE_CYC;
    localparam logic [WCNT_W-1:0] WAKE_LAST = WCNT_W'(WAKE_EFF - 1);

    cg_state_e         state;
    cg_state_e         next_state;
    logic [WCNT_W-1:0] wcnt;
    logic              idle;
    logic              hit;
    logic              icnt_clr;
    logic              icnt_inc;
    logic              wcnt_clr;
    logic              gate_inc;

    assign idle = !req_valid && !busy;

    nv_clk_gate_hyst_cnt #(
        .HYST_W (HYST_W)
    ) u_hyst (
        .clk    (clk),
        .reset_ (reset_),
        .clr    (icnt_clr),
        .inc    (icnt_inc),
        .thresh (idle_thresh),
        .hit    (hit)
    );

    always_comb begin
        next_state = state;
        icnt_clr   = 1'b0;
        icnt_inc   = 1'b0;
        wcnt_clr   = 1'b0;
        gate_inc   = 1'b0;
        unique case (state)
            CG_RUN: begin
                if (!idle || cg_disable) begin
                    icnt_clr = 1'b1;
                end else if (hit) begin
                    next_state = CG_GATED;
                    gate_inc   = 1'b1;
                end else begin
                    icnt_inc = 1'b1;
                end
            end
            CG_GATED: begin
                if (req_valid || busy || cg_disable) begin
                    next_state = CG_WAKE;
                    icnt_clr   = 1'b1;
                    wcnt_clr   = 1'b1;
                end
            end
            CG_WAKE: begin
                // warm-up always runs to completion
                if (wcnt == WAKE_LAST) begin
                    next_state = CG_RUN;
                end
            end
            default: next_state = CG_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state    <= CG_RUN;
            clk_en   <= 1'b1;
            wcnt     <= '0;
            gate_cnt <= '0;
        end else begin
            state  <= next_state;
            clk_en <= (next_state != CG_GATED);
            if (wcnt_clr) begin
                wcnt <= '0;
            end else if (state == CG_WAKE) begin
                wcnt <= wcnt + 1'b1;
            end
            if (gate_inc && (gate_cnt != '1)) begin
                gate_cnt <= gate_cnt + 1'b1;
            end
        end
    end

    assign req_ready = (state == CG_RUN);
    assign cg_state  = state;

endmodule

// File: tb/tb_nv_clk_gate_ctrl.sv
// Directed vector table plus hand sequences for the clock-gate controller.
module tb_nv_clk_gate_ctrl;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        req_valid = 1'b0;
    logic        busy = 1'b0;
    logic        cg_disable = 1'b0;
    logic [7:0]  idle_thresh = 8'd3;
    logic        req_ready;
    logic        clk_en;
    logic [1:0]  cg_state;
    logic [15:0] gate_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nv_clk_gate_ctrl #(
        .HYST_W   (8),
        .WAKE_CYC (2)
    ) dut (
        .clk         (clk),
        .reset_      (reset_),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .busy        (busy),
        .idle_thresh (idle_thresh),
        .cg_disable  (cg_disable),
        .clk_en      (clk_en),
        .cg_state    (cg_state),
        .gate_cnt    (gate_cnt)
    );

    typedef struct {
        logic        rv;
        logic        bz;
        logic        dis;
        logic [7:0]  th;
        logic        en;
        logic        rdy;
        logic [1:0]  st;
        logic [15:0] gc;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic en,
                           input logic rdy, input logic [1:0] st);
        chk({tag, ".clk_en"}, 32'(clk_en), 32'(en));
        chk({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
        chk({tag, ".cg_state"}, 32'(cg_state), 32'(st));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset_ = 1'b0;
        step();
        reset_ = 1'b1;
    endtask

    initial begin
        logic all_on;

        tbl[0]  = '{0, 0, 0, 8'd3, 1, 1, 2'd0, 16'd0};
        tbl[1]  = '{0, 0, 0, 8'd3, 1, 1, 2'd0, 16'd0};
        tbl[2]  = '{0, 0, 0, 8'd3, 1, 1, 2'd0, 16'd0};
        tbl[3]  = '{0, 0, 0, 8'd3, 0, 0, 2'd1, 16'd1};
        tbl[4]  = '{0, 0, 0, 8'd3, 0, 0, 2'd1, 16'd1};
        tbl[5]  = '{1, 0, 0, 8'd3, 1, 0, 2'd2, 16'd1};
        tbl[6]  = '{1, 0, 0, 8'd3, 1, 0, 2'd2, 16'd1};
        tbl[7]  = '{1, 0, 0, 8'd3, 1, 1, 2'd0, 16'd1};
        tbl[8]  = '{1, 0, 0, 8'd3, 1, 1, 2'd0, 16'd1};
        tbl[9]  = '{0, 0, 0, 8'd3, 1, 1, 2'd0, 16'd1};
        tbl[10] = '{0, 0, 0, 8'd3, 1, 1, 2'd0, 16'd1};
        tbl[11] = '{0, 0, 0, 8'd3, 1, 1, 2'd0, 16'd1};
        tbl[12] = '{0, 1, 0, 8'd3, 1, 1, 2'd0, 16'd1};
        tbl[13] = '{0, 0, 0, 8'd3, 1, 1, 2'd0, 16'd1};
        tbl[14] = '{0, 0, 0, 8'd3, 1, 1, 2'd0, 16'd1};
        tbl[15] = '{0, 0, 0, 8'd3, 1, 1, 2'd0, 16'd1};
        tbl[16] = '{0, 0, 0, 8'd3, 0, 0, 2'd1, 16'd2};
        tbl[17] = '{0, 0, 1, 8'd3, 1, 0, 2'd2, 16'd2};
        tbl[18] = '{0, 0, 0, 8'd3, 1, 0, 2'd2, 16'd2};
        tbl[19] = '{0, 0, 0, 8'd3, 1, 1, 2'd0, 16'd2};
        tbl[20] = '{0, 0, 0, 8'd0, 0, 0, 2'd1, 16'd3};

        // in reset with inputs idle
        step();
        step();
        chk_out("in_reset", 1'b1, 1'b1, 2'd0);
        chk("in_reset.gate_cnt", 32'(gate_cnt), 32'd0);
        reset_ = 1'b1;

        for (int i = 0; i < 21; i++) begin
            req_valid   = tbl[i].rv;
            busy        = tbl[i].bz;
            cg_disable  = tbl[i].dis;
            idle_thresh = tbl[i].th;
            step();
            chk_out($sformatf("vec%0d", i), tbl[i].en, tbl[i].rdy, tbl[i].st);
            chk($sformatf("vec%0d.gate_cnt", i), 32'(gate_cnt), 32'(tbl[i].gc));
        end

        // software override holds the clock on with T=0
        req_valid   = 1'b0;
        busy        = 1'b0;
        cg_disable  = 1'b1;
        idle_thresh = 8'd0;
        reset_pulse();
        all_on = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (clk_en !== 1'b1 || cg_state !== 2'd0) all_on = 1'b0;
        end
        chk("dis.held_on", 32'(all_on), 32'd1);
        chk("dis.gate_cnt", 32'(gate_cnt), 32'd0);
        cg_disable = 1'b0;
        step();
        chk_out("dis.gated", 1'b0, 1'b0, 2'd1);
        cg_disable = 1'b1;
        step();
        chk_out("dis.wake0", 1'b1, 1'b0, 2'd2);
        step();
        chk_out("dis.wake1", 1'b1, 1'b0, 2'd2);
        cg_disable = 1'b0;
        step();
        chk_out("dis.run", 1'b1, 1'b1, 2'd0);
        chk("dis.gate_cnt1", 32'(gate_cnt), 32'd1);

        // threshold lowered below a running count of 50
        idle_thresh = 8'd200;
        reset_pulse();
        for (int i = 0; i < 50; i++) step();
        chk_out("thr.before", 1'b1, 1'b1, 2'd0);
        idle_thresh = 8'd5;
        step();
        chk_out("thr.after", 1'b0, 1'b0, 2'd1);

        // gate counter saturation, preloaded near the top
        idle_thresh = 8'd0;
        reset_pulse();
        force dut.gate_cnt = 16'hFFFD;
        #1;
        release dut.gate_cnt;
        for (int r = 0; r < 4; r++) begin
            busy = 1'b0;
            step();
            busy = 1'b1;
            step();
            busy = 1'b0;
            step();
            step();
            if (r == 1) chk("sat.reach", 32'(gate_cnt), 32'hFFFF);
        end
        chk("sat.hold", 32'(gate_cnt), 32'hFFFF);
        chk_out("sat.run", 1'b1, 1'b1, 2'd0);

        // asynchronous reset in the middle of WAKE
        step();
        chk_out("rw.gated", 1'b0, 1'b0, 2'd1);
        busy = 1'b1;
        step();
        busy = 1'b0;
        step();
        chk_out("rw.wake", 1'b1, 1'b0, 2'd2);
        #2;
        reset_ = 1'b0;
        #1;
        chk_out("rw.reset", 1'b1, 1'b1, 2'd0);
        chk("rw.gate_cnt", 32'(gate_cnt), 32'd0);
        step();
        reset_ = 1'b1;

        // asynchronous reset while GATED
        step();
        chk_out("rg.gated", 1'b0, 1'b0, 2'd1);
        #2;
        reset_ = 1'b0;
        #1;
        chk_out("rg.reset", 1'b1, 1'b1, 2'd0);
        step();
        reset_ = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nv_clk_gate_ctrl.md
# nv_clk_gate_ctrl

Controller that drives the `clk_en` input of a power clock-gate cell from activity seen at the gated domain's boundary. It watches incoming requests and the domain's busy flag. After a programmable number of consecutive idle cycles it drops `clk_en`. On new activity it re-enables the clock and holds off request acceptance until the domain has had a fixed number of warm-up cycles. It sits on the always-on clock beside each gated sub-unit and is the only source of that unit's `clk_en`.

## Interface
Parameters:
- `HYST_W`, default 8: width of the idle threshold and the idle counter.
- `WAKE_CYC`, default 2: number of clock-on cycles between leaving GATED and `req_ready`. Legal range is 1..15.

Ports:
- `clk` in 1: ungated clock.
- `reset_` in 1: asynchronous, active-low reset.
- `req_valid` in 1: upstream request pending. It must be held until `req_ready`.
- `req_ready` out 1: the gated domain can accept the request.
- `busy` in 1: the gated domain has work in flight.
- `idle_thresh` in `HYST_W`: idle cycles required before gating. Quasi-static.
- `cg_disable` in 1: software override that keeps the clock on.
- `clk_en` out 1: enable to the clock-gate cell. Registered.
- `cg_state` out 2: current state; RUN=0, GATED=1, WAKE=2.
- `gate_cnt` out 16: saturating count of RUN→GATED transitions.

## Operation
- `idle` = `!req_valid && !busy`.
- **RUN**
  - `clk_en`=1 and `req_ready`=1.
  - If `!idle` or `cg_disable`, the idle counter `icnt` is cleared to 0.
  - Otherwise, if `icnt >= idle_thresh`, go to GATED and increment `gate_cnt` (saturating at 0xFFFF).
  - Otherwise `icnt` increments, saturating at all-ones.
- **GATED**
  - `clk_en`=0 and `req_ready`=0.
  - If `req_valid`, `busy` or `cg_disable` is asserted, go to WAKE, clear `icnt`, and load the wake counter `wcnt`=0.
- **WAKE**
  - `clk_en`=1 and `req_ready`=0.
  - `wcnt` increments each cycle. When `wcnt == WAKE_CYC-1`, go to RUN.
  - WAKE is never aborted: `cg_disable` and inputs dropping have no effect here.
- Outputs:
  - `req_ready` and `cg_state` are decoded from the state register.
  - `clk_en` is a flop whose next value is `next_state != GATED`. This makes it glitch-free, and the gate cell sees it change in the same cycle as `cg_state`.
- Reset values: state=RUN, `clk_en`=1, `req_ready`=1, `cg_state`=0, `icnt`=0, `wcnt`=0, `gate_cnt`=0. `clk_en` is never X after reset deassertion.

## Timing
- Gating latency with `idle_thresh`=T: `idle` must hold for cycles c..c+T. GATED (`clk_en`=0) is seen in cycle c+T+1. T=0 gates one cycle after the first idle cycle.
- Activity breaking the idle run in any RUN cycle clears `icnt`. The count restarts from 0 on the next idle cycle.
- A wake source sampled in GATED cycle g gives `clk_en`=1 from g+1 and `req_ready`=1 from g+1+`WAKE_CYC`.
- `req_valid` and the gating decision in the same cycle: `req_valid` makes `idle` false, so there is no transition. A request is never dropped and `req_ready` never falls while `req_valid` is high in RUN.
- `idle_thresh` lowered below the current `icnt`: gating happens on the next idle cycle, because the test is `>=`. There is no wrap miss.
- Asynchronous reset mid-WAKE or mid-GATED returns to RUN immediately with `clk_en`=1.

## Structure
- Package `nv_clk_gate_pkg` holds:
  - the state enum (`CG_RUN`, `CG_GATED`, `CG_WAKE`) with its 2-bit encodings;
  - the `WAKE_CYC` legal-range constant;
  - the `gate_cnt` width constant (16).
- One sub-module, `nv_clk_gate_hyst_cnt`, holds the `HYST_W` saturating idle counter. Its inputs are clear, increment and threshold; its output is `hit`.
- The top level holds the FSM, the wake counter, `gate_cnt` and the output flops.

## Test plan
- Reset with all inputs low and T=3 → `clk_en`=1 and `cg_state`=0 during reset. `clk_en`=0 exactly 4 cycles after reset release. `gate_cnt`=1.
- T=3 with a `busy` pulse after 3 idle cycles → no gating. Gating occurs 4 idle cycles after the pulse.
- In GATED, assert `req_valid` with `WAKE_CYC`=2 → `clk_en`=1 the next cycle. `req_ready`=1 three cycles after `req_valid` is sampled. `cg_state` goes 1→2→2→0.
- `cg_disable`=1 with inputs idle for 300 cycles and T=0 → `clk_en` stays 1 and `gate_cnt` stays 0. Raising `cg_disable` in GATED → wake sequence as above.
- Change `idle_thresh` from 200 to 5 while `icnt`=50 → GATED on the next idle cycle.
- Force 70000 gate/wake cycles → `gate_cnt` saturates at 0xFFFF. Assert `reset_` mid-WAKE → `clk_en`=1 and `cg_state`=0 immediately.
